// File: rtl/seg_decoder_driver.sv
// Registered seven-segment driver for one HEX digit: latches a value on load and drives
// the active-low pattern, with a prescaled blink mode and a lamp test.
module seg_decoder_driver #(
    parameter int unsigned BLINK_HALF = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] val,
    input  logic       blink,
    input  logic       lamp_test,
    output logic [6:0] hex,
    output logic [3:0] cur_val,
    output logic       visible
);

    localparam int unsigned CW = $clog2(BLINK_HALF);

    logic [3:0]    val_q;
    logic          loaded;
    logic [CW-1:0] cnt;
    logic          phase;

    logic [3:0]    val_n;
    logic          loaded_n;
    logic [CW-1:0] cnt_n;
    logic          phase_n;
    logic [6:0]    hex_n;
    logic          visible_n;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] seg;
        case (v)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    // Next-state: load wins over blink stepping; blink off holds the visible phase.
    always_comb begin
        val_n    = val_q;
        loaded_n = loaded;
        cnt_n    = '0;
        phase_n  = 1'b1;
        if (load) begin
            val_n    = val;
            loaded_n = 1'b1;
        end else if (blink) begin
            if (cnt == CW'(BLINK_HALF - 1)) begin
                phase_n = ~phase;
            end else begin
                cnt_n   = cnt + CW'(1);
                phase_n = phase;
            end
        end
    end

    // Outputs derive from next-state so a sampled input shows one edge later.
    always_comb begin
        hex_n     = 7'b1111111;
        visible_n = 1'b0;
        if (lamp_test) begin
            hex_n = 7'b0000000;
        end else if (loaded_n && phase_n) begin
            hex_n     = decode(val_n);
            visible_n = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            val_q   <= 4'd0;
            loaded  <= 1'b0;
            cnt     <= '0;
            phase   <= 1'b1;
            hex     <= 7'b1111111;
            cur_val <= 4'd0;
            visible <= 1'b0;
        end else begin
            val_q   <= val_n;
            loaded  <= loaded_n;
            cnt     <= cnt_n;
            phase   <= phase_n;
            hex     <= hex_n;
            cur_val <= val_n;
            visible <= visible_n;
        end
    end

endmodule

// File: tb/tb_seg_decoder_driver.sv
// Directed bench for seg_decoder_driver with BLINK_HALF=4: decode table, blink timing,
// lamp test, async reset and load gating.
module tb_seg_decoder_driver;

    logic       clk;
    logic       reset;
    logic       load;
    logic [3:0] val;
    logic       blink;
    logic       lamp_test;
    logic [6:0] hex;
    logic [3:0] cur_val;
    logic       visible;

    int n_checks = 0;
    int n_pass   = 0;

    logic [6:0] seg_tbl [16];

    seg_decoder_driver #(.BLINK_HALF(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .val       (val),
        .blink     (blink),
        .lamp_test (lamp_test),
        .hex       (hex),
        .cur_val   (cur_val),
        .visible   (visible)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [6:0] act, input logic [6:0] exp);
        n_checks++;
        assert (act === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, act, exp);
    endtask

    task automatic check_all(input string tag, input logic [6:0] eh, input logic [3:0] ec, input logic ev);
        check({tag, ".hex"}, hex, eh);
        check({tag, ".cur_val"}, 7'(cur_val), 7'(ec));
        check({tag, ".visible"}, 7'(visible), 7'(ev));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        seg_tbl[0]  = 7'b1000000; seg_tbl[1]  = 7'b1111001;
        seg_tbl[2]  = 7'b0100100; seg_tbl[3]  = 7'b0110000;
        seg_tbl[4]  = 7'b0011001; seg_tbl[5]  = 7'b0010010;
        seg_tbl[6]  = 7'b0000010; seg_tbl[7]  = 7'b1111000;
        seg_tbl[8]  = 7'b0000000; seg_tbl[9]  = 7'b0010000;
        seg_tbl[10] = 7'b0001000; seg_tbl[11] = 7'b0000011;
        seg_tbl[12] = 7'b1000110; seg_tbl[13] = 7'b0100001;
        seg_tbl[14] = 7'b0000110; seg_tbl[15] = 7'b0001110;

        reset = 1'b1; load = 1'b0; val = 4'd0; blink = 1'b0; lamp_test = 1'b0;
        #12 reset = 1'b0;

        // idle after reset
        repeat (5) step();
        check_all("reset_idle", 7'b1111111, 4'd0, 1'b0);

        // full decode table, one load per cycle
        for (int i = 0; i < 16; i++) begin
            load = 1'b1; val = 4'(i);
            step();
            check_all($sformatf("decode_%0h", i), seg_tbl[i], 4'(i), 1'b1);
        end
        load = 1'b0;

        // blink: 4 on, 4 off, 4 on starting at the load edge
        load = 1'b1; val = 4'd5; blink = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            load = 1'b0;
            if (((k / 4) % 2) == 0)
                check_all($sformatf("blink_on_%0d", k), 7'b0010010, 4'd5, 1'b1);
            else
                check_all($sformatf("blink_off_%0d", k), 7'b1111111, 4'd5, 1'b0);
        end
        step(); check_all("blink_off_a", 7'b1111111, 4'd5, 1'b0);
        step(); check_all("blink_off_b", 7'b1111111, 4'd5, 1'b0);

        // load during off phase restarts a full on phase
        load = 1'b1; val = 4'd7;
        for (int k = 0; k < 4; k++) begin
            step();
            load = 1'b0;
            check_all($sformatf("reload_on_%0d", k), 7'b1111000, 4'd7, 1'b1);
        end
        step(); check_all("reload_off", 7'b1111111, 4'd7, 1'b0);

        // lamp test while blinking 2; counter keeps running underneath
        load = 1'b1; val = 4'd2;
        step(); load = 1'b0;
        check_all("lamp_pre", 7'b0100100, 4'd2, 1'b1);
        lamp_test = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check_all($sformatf("lamp_%0d", k), 7'b0000000, 4'd2, 1'b0);
        end
        lamp_test = 1'b0;
        step(); check_all("lamp_rel_off", 7'b1111111, 4'd2, 1'b0);
        step(); check_all("lamp_rel_on", 7'b0100100, 4'd2, 1'b1);

        // async reset mid-cycle while showing E
        blink = 1'b0; load = 1'b1; val = 4'hE;
        step(); load = 1'b0;
        check_all("pre_reset_E", 7'b0000110, 4'hE, 1'b1);
        #3 reset = 1'b1;
        #1 check_all("async_reset", 7'b1111111, 4'd0, 1'b0);
        #1 reset = 1'b0;
        blink = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check_all($sformatf("post_reset_blank_%0d", k), 7'b1111111, 4'd0, 1'b0);
        end

        // val changes without load are ignored
        blink = 1'b0; load = 1'b1; val = 4'd9;
        step(); load = 1'b0;
        check_all("show_9", 7'b0010000, 4'd9, 1'b1);
        val = 4'd3;
        step(); check_all("ignore_3", 7'b0010000, 4'd9, 1'b1);
        val = 4'hA;
        step(); check_all("ignore_A", 7'b0010000, 4'd9, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
